// File: rtl/riscv_ahb3lite_cache_arb_if.sv
// AHB3-Lite signal bundle shared by the cache ports and the system bus port of the cache arbiter.
// master modport drives address/control/write data; slave modport returns read data and response.
interface riscv_ahb3lite_cache_arb_if #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned PHYS_ADDR_SIZE = XLEN
);
    logic                      HSEL;
    logic [PHYS_ADDR_SIZE-1:0] HADDR;
    logic [XLEN-1:0]           HWDATA;
    logic [XLEN-1:0]           HRDATA;
    logic                      HWRITE;
    logic [2:0]                HSIZE;
    logic [2:0]                HBURST;
    logic [3:0]                HPROT;
    logic [1:0]                HTRANS;
    logic                      HMASTLOCK;
    logic                      HREADY;
    logic                      HRESP;

    modport master (
        output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/riscv_ahb3lite_cache_arb.sv
// Two-to-one AHB3-Lite arbiter: dcache (mst0_io) and icache (mst1_io) share one bus port (bus_io).
// Optional RISCV_ARB_LOCK_EN makes HMASTLOCK hold the grant on the current owner.
module riscv_ahb3lite_cache_arb #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned PHYS_ADDR_SIZE = XLEN,
    parameter int unsigned DEFAULT_MST    = 0
) (
    input  logic                         HCLK,
    input  logic                         HRESET,
    riscv_ahb3lite_cache_arb_if.slave    mst0_io,
    riscv_ahb3lite_cache_arb_if.slave    mst1_io,
    riscv_ahb3lite_cache_arb_if.master   bus_io
);
    typedef enum logic {StOwn0, StOwn1} own_e;

    localparam own_e       RstOwn     = (DEFAULT_MST != 0) ? StOwn1 : StOwn0;
    localparam logic       RstDown    = (DEFAULT_MST != 0);
    localparam logic [1:0] HtransIdle = 2'b00;

    own_e aown_q, aown_d;
    logic down_q, down_d;
    logic dval_q, dval_d;
    logic aown;
    logic locked;

    logic                      m_hsel      [2];
    logic [PHYS_ADDR_SIZE-1:0] m_haddr     [2];
    logic [XLEN-1:0]           m_hwdata    [2];
    logic                      m_hwrite    [2];
    logic [2:0]                m_hsize     [2];
    logic [2:0]                m_hburst    [2];
    logic [3:0]                m_hprot     [2];
    logic [1:0]                m_htrans    [2];
    logic                      m_hmastlock [2];
    logic [1:0]                req;
    logic [1:0]                own_a;
    logic [1:0]                own_d;

    assign m_hsel[0]      = mst0_io.HSEL;       assign m_hsel[1]      = mst1_io.HSEL;
    assign m_haddr[0]     = mst0_io.HADDR;      assign m_haddr[1]     = mst1_io.HADDR;
    assign m_hwdata[0]    = mst0_io.HWDATA;     assign m_hwdata[1]    = mst1_io.HWDATA;
    assign m_hwrite[0]    = mst0_io.HWRITE;     assign m_hwrite[1]    = mst1_io.HWRITE;
    assign m_hsize[0]     = mst0_io.HSIZE;      assign m_hsize[1]     = mst1_io.HSIZE;
    assign m_hburst[0]    = mst0_io.HBURST;     assign m_hburst[1]    = mst1_io.HBURST;
    assign m_hprot[0]     = mst0_io.HPROT;      assign m_hprot[1]     = mst1_io.HPROT;
    assign m_htrans[0]    = mst0_io.HTRANS;     assign m_htrans[1]    = mst1_io.HTRANS;
    assign m_hmastlock[0] = mst0_io.HMASTLOCK;  assign m_hmastlock[1] = mst1_io.HMASTLOCK;

    assign aown  = (aown_q == StOwn1);
    assign req   = {m_htrans[1][1], m_htrans[0][1]};
    assign own_a = {aown, ~aown};
    assign own_d = dval_q ? {down_q, ~down_q} : 2'b00;

`ifdef RISCV_ARB_LOCK_EN
    logic lock_q, lock_d;

    // Lock also covers the IDLE right after a locked address, so the grant is released one
    // accepted unlocked address later.
    assign locked = m_hmastlock[aown] | lock_q;
    assign lock_d = bus_io.HREADY ? m_hmastlock[aown] : lock_q;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) lock_q <= 1'b0;
        else        lock_q <= lock_d;
    end
`else
    assign locked = 1'b0;
`endif

    always_comb begin
        aown_d = aown_q;
        down_d = down_q;
        dval_d = dval_q;
        if (bus_io.HREADY) begin
            down_d = aown;
            dval_d = m_htrans[aown][1];
            unique case (aown_q)
                StOwn0: if (m_htrans[0] == HtransIdle && req[1] && !locked) aown_d = StOwn1;
                StOwn1: if (m_htrans[1] == HtransIdle && req[0] && !locked) aown_d = StOwn0;
                default: aown_d = RstOwn;
            endcase
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            aown_q <= RstOwn;
            down_q <= RstDown;
            dval_q <= 1'b0;
        end else begin
            aown_q <= aown_d;
            down_q <= down_d;
            dval_q <= dval_d;
        end
    end

    assign bus_io.HSEL      = m_hsel[aown];
    assign bus_io.HADDR     = m_haddr[aown];
    assign bus_io.HWRITE    = m_hwrite[aown];
    assign bus_io.HSIZE     = m_hsize[aown];
    assign bus_io.HBURST    = m_hburst[aown];
    assign bus_io.HPROT     = m_hprot[aown];
    assign bus_io.HTRANS    = m_htrans[aown];
    assign bus_io.HMASTLOCK = m_hmastlock[aown];
    assign bus_io.HWDATA    = m_hwdata[down_q];

    // A waiting non-owner sees HREADY low so it keeps its address stable until granted.
    assign mst0_io.HREADY = (own_a[0] | own_d[0]) ? bus_io.HREADY : ~req[0];
    assign mst1_io.HREADY = (own_a[1] | own_d[1]) ? bus_io.HREADY : ~req[1];
    assign mst0_io.HRESP  = own_d[0] & bus_io.HRESP;
    assign mst1_io.HRESP  = own_d[1] & bus_io.HRESP;
    assign mst0_io.HRDATA = bus_io.HRDATA;
    assign mst1_io.HRDATA = bus_io.HRDATA;
endmodule

// File: tb/tb_riscv_ahb3lite_cache_arb.sv
// Directed bench for riscv_ahb3lite_cache_arb: reset, burst protection, parking, stalls, ERROR, lock.
// Expectations for the lock sequence depend on RISCV_ARB_LOCK_EN.
module tb_riscv_ahb3lite_cache_arb;
    localparam logic [1:0] Idle = 2'b00, Nonseq = 2'b10, Seq = 2'b11;
    localparam logic [2:0] Single = 3'd0, Incr8 = 3'd5;

    logic HCLK;
    logic HRESET;
    int   vectors     = 0;
    int   miscompares = 0;

    riscv_ahb3lite_cache_arb_if dc_if ();
    riscv_ahb3lite_cache_arb_if ic_if ();
    riscv_ahb3lite_cache_arb_if bus_if ();

    riscv_ahb3lite_cache_arb #(
        .XLEN           (32),
        .PHYS_ADDR_SIZE (32),
        .DEFAULT_MST    (0)
    ) dut (
        .HCLK    (HCLK),
        .HRESET  (HRESET),
        .mst0_io (dc_if),
        .mst1_io (ic_if),
        .bus_io  (bus_if)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge HCLK);
        #1;
    endtask

    task automatic smp();
        @(negedge HCLK);
    endtask

    task automatic dc_drv(input logic [1:0] tr, input logic [31:0] a, input logic w,
                          input logic [2:0] b, input logic lk);
        dc_if.HSEL = tr[1]; dc_if.HTRANS = tr; dc_if.HADDR = a; dc_if.HWRITE = w;
        dc_if.HBURST = b; dc_if.HMASTLOCK = lk; dc_if.HSIZE = 3'd2; dc_if.HPROT = 4'b0011;
    endtask

    task automatic ic_drv(input logic [1:0] tr, input logic [31:0] a);
        ic_if.HSEL = tr[1]; ic_if.HTRANS = tr; ic_if.HADDR = a; ic_if.HWRITE = 1'b0;
        ic_if.HBURST = Single; ic_if.HMASTLOCK = 1'b0; ic_if.HSIZE = 3'd2; ic_if.HPROT = 4'b0010;
    endtask

    initial begin
        HRESET = 1'b1;
        bus_if.HREADY = 1'b1; bus_if.HRESP = 1'b0; bus_if.HRDATA = '0;
        dc_if.HWDATA = '0; ic_if.HWDATA = '0;
        dc_drv(Idle, 32'hAAA0, 1'b0, Single, 1'b0);
        ic_drv(Idle, 32'hBBB0);
        smp();
        chk("rst_htrans", {30'd0, bus_if.HTRANS}, 32'd0);
        chk("rst_haddr_dcache", bus_if.HADDR, 32'hAAA0);
        chk("rst_hready", {30'd0, ic_if.HREADY, dc_if.HREADY}, 32'd3);
        chk("rst_hresp", {30'd0, ic_if.HRESP, dc_if.HRESP}, 32'd0);
        HRESET = 1'b0;
        nxt();

        // dcache INCR8; icache starts requesting at beat 3
        for (int i = 0; i < 8; i++) begin
            dc_drv((i == 0) ? Nonseq : Seq, 32'h1000 + 32'(4 * i), 1'b0, Incr8, 1'b0);
            if (i >= 2) ic_drv(Nonseq, 32'h100);
            bus_if.HRDATA = 32'hD000 + 32'(i);
            smp();
            chk("burst_haddr", bus_if.HADDR, 32'h1000 + 32'(4 * i));
            chk("burst_htrans", {30'd0, bus_if.HTRANS}, {30'd0, (i == 0) ? Nonseq : Seq});
            chk("burst_ic_hready", {31'd0, ic_if.HREADY}, (i >= 2) ? 32'd0 : 32'd1);
            nxt();
        end
        dc_drv(Idle, 32'h1FF0, 1'b0, Single, 1'b0);
        bus_if.HRDATA = 32'hD008;
        smp();
        chk("sw_idle_htrans", {30'd0, bus_if.HTRANS}, 32'd0);
        chk("sw_idle_ic_hready", {31'd0, ic_if.HREADY}, 32'd0);
        chk("sw_idle_dc_hready", {31'd0, dc_if.HREADY}, 32'd1);
        chk("ic_hrdata_bcast", ic_if.HRDATA, 32'hD008);
        nxt();
        smp();
        chk("ic_nonseq_haddr", bus_if.HADDR, 32'h100);
        chk("ic_nonseq_htrans", {30'd0, bus_if.HTRANS}, {30'd0, Nonseq});
        chk("ic_nonseq_hready", {31'd0, ic_if.HREADY}, 32'd1);
        chk("dc_idle_hready", {31'd0, dc_if.HREADY}, 32'd1);
        nxt();

        // both idle: bus stays parked on icache
        ic_drv(Idle, 32'h104);
        for (int i = 0; i < 2; i++) begin
            smp();
            chk("park_haddr", bus_if.HADDR, 32'h104);
            nxt();
        end

        // dcache single write after park
        dc_drv(Nonseq, 32'h2000, 1'b1, Single, 1'b0);
        smp();
        chk("wr_wait_htrans", {30'd0, bus_if.HTRANS}, 32'd0);
        chk("wr_wait_dc_hready", {31'd0, dc_if.HREADY}, 32'd0);
        nxt();
        smp();
        chk("wr_haddr", bus_if.HADDR, 32'h2000);
        chk("wr_hwrite", {31'd0, bus_if.HWRITE}, 32'd1);
        chk("wr_dc_hready", {31'd0, dc_if.HREADY}, 32'd1);
        nxt();
        dc_drv(Idle, 32'h2FF0, 1'b0, Single, 1'b0);
        dc_if.HWDATA = 32'hCAFE_0001; ic_if.HWDATA = 32'h0BAD_0BAD;
        smp();
        chk("wr_hwdata", bus_if.HWDATA, 32'hCAFE_0001);
        nxt();

        // switch request while old owner's last beat stalls 3 cycles
        dc_drv(Nonseq, 32'h3000, 1'b0, Single, 1'b0);
        ic_drv(Nonseq, 32'h200);
        smp();
        chk("stall_addr", bus_if.HADDR, 32'h3000);
        chk("stall_ic_hready0", {31'd0, ic_if.HREADY}, 32'd0);
        nxt();
        dc_drv(Idle, 32'h3FF0, 1'b0, Single, 1'b0);
        bus_if.HREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            smp();
            chk("stall_keep_aown", bus_if.HADDR, 32'h3FF0);
            chk("stall_dc_hready", {31'd0, dc_if.HREADY}, 32'd0);
            chk("stall_ic_hready", {31'd0, ic_if.HREADY}, 32'd0);
            nxt();
        end
        bus_if.HREADY = 1'b1; bus_if.HRDATA = 32'h1234_5678;
        smp();
        chk("stall_dc_hrdata", dc_if.HRDATA, 32'h1234_5678);
        chk("stall_dc_done", {31'd0, dc_if.HREADY}, 32'd1);
        chk("stall_ic_still_wait", {31'd0, ic_if.HREADY}, 32'd0);
        nxt();
        smp();
        chk("stall_ic_haddr", bus_if.HADDR, 32'h200);
        chk("stall_ic_granted", {31'd0, ic_if.HREADY}, 32'd1);
        nxt();
        ic_drv(Idle, 32'h2FC);
        bus_if.HRDATA = 32'h55;
        smp();
        chk("ic_data_hready", {31'd0, ic_if.HREADY}, 32'd1);
        nxt();

        // ERROR on dcache single read
        dc_drv(Nonseq, 32'h4000, 1'b0, Single, 1'b0);
        smp();
        chk("err_wait_dc_hready", {31'd0, dc_if.HREADY}, 32'd0);
        nxt();
        smp();
        chk("err_haddr", bus_if.HADDR, 32'h4000);
        nxt();
        dc_drv(Idle, 32'h4FF0, 1'b0, Single, 1'b0);
        bus_if.HREADY = 1'b0; bus_if.HRESP = 1'b1;
        smp();
        chk("err1_dc_hresp", {31'd0, dc_if.HRESP}, 32'd1);
        chk("err1_dc_hready", {31'd0, dc_if.HREADY}, 32'd0);
        chk("err1_ic_hresp", {31'd0, ic_if.HRESP}, 32'd0);
        nxt();
        bus_if.HREADY = 1'b1;
        smp();
        chk("err2_dc_hresp", {31'd0, dc_if.HRESP}, 32'd1);
        chk("err2_dc_hready", {31'd0, dc_if.HREADY}, 32'd1);
        chk("err2_ic_hresp", {31'd0, ic_if.HRESP}, 32'd0);
        nxt();
        bus_if.HRESP = 1'b0;
        smp();
        chk("err_done_dc_hresp", {31'd0, dc_if.HRESP}, 32'd0);
        nxt();

        // locked sequence with icache requesting
        dc_drv(Nonseq, 32'h5000, 1'b0, Single, 1'b1);
        ic_drv(Nonseq, 32'h300);
        smp();
        chk("lk_haddr", bus_if.HADDR, 32'h5000);
        chk("lk_hmastlock", {31'd0, bus_if.HMASTLOCK}, 32'd1);
        nxt();
        dc_drv(Idle, 32'h5FF0, 1'b0, Single, 1'b1);
        smp();
        chk("lk_idle_htrans", {30'd0, bus_if.HTRANS}, 32'd0);
        nxt();
        dc_drv(Nonseq, 32'h5000, 1'b1, Single, 1'b1);
        smp();
`ifdef RISCV_ARB_LOCK_EN
        chk("lk_wr_haddr", bus_if.HADDR, 32'h5000);
        chk("lk_wr_dc_hready", {31'd0, dc_if.HREADY}, 32'd1);
        nxt();
        dc_drv(Idle, 32'h5FF0, 1'b0, Single, 1'b0);
        smp();
        chk("lk_release1_haddr", bus_if.HADDR, 32'h5FF0);
        chk("lk_release1_ic_hready", {31'd0, ic_if.HREADY}, 32'd0);
        nxt();
        smp();
        chk("lk_release2_haddr", bus_if.HADDR, 32'h5FF0);
        nxt();
        smp();
        chk("lk_switch_haddr", bus_if.HADDR, 32'h300);
        chk("lk_switch_ic_hready", {31'd0, ic_if.HREADY}, 32'd1);
`else
        chk("nolk_switch_haddr", bus_if.HADDR, 32'h300);
        chk("nolk_dc_hready", {31'd0, dc_if.HREADY}, 32'd0);
`endif
        nxt();

        // reset while icache owns the bus
        dc_drv(Idle, 32'h6000, 1'b0, Single, 1'b0);
        HRESET = 1'b1;
        #1;
        chk("midrst_haddr", bus_if.HADDR, 32'h6000);
        chk("midrst_ic_hready", {31'd0, ic_if.HREADY}, 32'd0);
        chk("midrst_hresp", {30'd0, ic_if.HRESP, dc_if.HRESP}, 32'd0);
        HRESET = 1'b0;
        nxt();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
